// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder with RX/TX byte FIFOs behind a strobe interface.
// Optional sticky overrun/underrun flags with clear input: SPI_RESP_ERR_EN.
module spi_responder #(
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       spi_sck_in,
  input  logic       spi_cs_in,
  input  logic       spi_mosi_in,
  output logic       spi_miso_out,
  input  logic       slv_rd,
  input  logic       slv_wr,
  input  logic [7:0] slv_din,
  output logic [7:0] slv_dout,
  output logic       slv_data_avail,
  output logic       slv_tx_empty,
  output logic       slv_tx_full,
  output logic       slv_busy
`ifdef SPI_RESP_ERR_EN
  ,
  input  logic       slv_err_clr,
  output logic       slv_rx_overrun,
  output logic       slv_tx_underrun
`endif
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam logic [RAW:0] RX_ONE = 1;
  localparam logic [TAW:0] TX_ONE = 1;

  typedef enum logic { S_IDLE, S_ACTIVE } state_t;

  // Synchronizer bit order: {cs, sck, mosi}; cs flops reset high (deselected).
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0] prev_q, prev_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;

  logic [7:0]   rx_mem_q [RX_DEPTH];
  logic [7:0]   rx_mem_d [RX_DEPTH];
  logic [RAW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [7:0]   tx_mem_d [TX_DEPTH];
  logic [TAW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;

  logic cs_sync, sck_sync, mosi_sync, cs_fall, sck_rise, sck_fall;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_rd_ok, rx_wr_ok, tx_pop_req, tx_pop_ok, tx_wr_ok;
  logic [7:0] tx_next;

  assign cs_sync   = sync2_q[2];
  assign sck_sync  = sync2_q[1];
  assign mosi_sync = sync2_q[0];
  assign sck_rise  = sck_sync & ~prev_q[0];
  assign sck_fall  = ~sck_sync & prev_q[0];
  // A fall only counts once CS has been seen high after reset has flushed the synchronizers.
  assign cs_fall   = armed_q & ~cs_sync & prev_q[1];

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) && (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) && (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);
  assign tx_next  = tx_empty ? FILL_BYTE : tx_mem_q[tx_rptr_q[TAW-1:0]];

  always_comb begin
    sync1_d     = {spi_cs_in, spi_sck_in, spi_mosi_in};
    sync2_d     = sync1_q;
    prev_d      = sync2_q[2:1];
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | ((settle_q == 2'd3) & cs_sync);
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    tx_pop_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d   = 3'd0;
        byte_done_d = 1'b0;
        if (cs_fall) begin
          state_d    = S_ACTIVE;
          tx_pop_req = 1'b1;
          tx_shift_d = tx_next;
        end
      end
      default: begin
        if (cs_sync) begin
          state_d     = S_IDLE;
          bit_cnt_d   = 3'd0;
          byte_done_d = 1'b0;
          rx_shift_d  = 8'h00;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_sync};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_push     = 1'b1;
            byte_done_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (byte_done_q) begin
            tx_pop_req  = 1'b1;
            tx_shift_d  = tx_next;
            byte_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
    endcase
  end

  // A full FIFO still accepts a write when a same-cycle pop frees the slot.
  always_comb begin
    rx_rd_ok  = slv_rd & ~rx_empty;
    rx_wr_ok  = rx_push & (~rx_full | rx_rd_ok);
    tx_pop_ok = tx_pop_req & ~tx_empty;
    tx_wr_ok  = slv_wr & (~tx_full | tx_pop_ok);
    rx_mem_d  = rx_mem_q;
    tx_mem_d  = tx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (rx_wr_ok) begin
      rx_mem_d[rx_wptr_q[RAW-1:0]] = rx_shift_d;
      rx_wptr_d = rx_wptr_q + RX_ONE;
    end
    if (rx_rd_ok) rx_rptr_d = rx_rptr_q + RX_ONE;
    if (tx_wr_ok) begin
      tx_mem_d[tx_wptr_q[TAW-1:0]] = slv_din;
      tx_wptr_d = tx_wptr_q + TX_ONE;
    end
    if (tx_pop_ok) tx_rptr_d = tx_rptr_q + TX_ONE;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      sync1_q     <= 3'b100;
      sync2_q     <= 3'b100;
      prev_q      <= 2'b10;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'h00;
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= 8'h00;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      rx_mem_q    <= rx_mem_d;
      tx_mem_q    <= tx_mem_d;
    end
  end

  assign spi_miso_out   = (state_q == S_ACTIVE) & tx_shift_q[7];
  assign slv_dout       = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q[RAW-1:0]];
  assign slv_data_avail = ~rx_empty;
  assign slv_tx_empty   = tx_empty;
  assign slv_tx_full    = tx_full;
  assign slv_busy       = ~cs_sync;

`ifdef SPI_RESP_ERR_EN
  logic ovr_q, ovr_d, und_q, und_d;
  always_comb begin
    ovr_d = (rx_push & rx_full & ~rx_rd_ok) | (ovr_q & ~slv_err_clr);
    und_d = (tx_pop_req & tx_empty) | (und_q & ~slv_err_clr);
  end
  always_ff @(posedge clk) begin
    if (Rst) begin
      ovr_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      und_q <= und_d;
    end
  end
  assign slv_rx_overrun  = ovr_q;
  assign slv_tx_underrun = und_q;
`endif
endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - directed table-driven bench for spi_responder.
module tb_spi_responder;
  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso_out;
  logic       slv_rd = 1'b0, slv_wr = 1'b0;
  logic [7:0] slv_din = 8'h00;
  logic [7:0] slv_dout;
  logic       slv_data_avail, slv_tx_empty, slv_tx_full, slv_busy;
`ifdef SPI_RESP_ERR_EN
  logic       slv_err_clr = 1'b0;
  logic       slv_rx_overrun, slv_tx_underrun;
`endif

  spi_responder dut (
    .clk(clk), .Rst(Rst),
    .spi_sck_in(spi_sck), .spi_cs_in(spi_cs), .spi_mosi_in(spi_mosi),
    .spi_miso_out(spi_miso_out),
    .slv_rd(slv_rd), .slv_wr(slv_wr), .slv_din(slv_din), .slv_dout(slv_dout),
    .slv_data_avail(slv_data_avail), .slv_tx_empty(slv_tx_empty),
    .slv_tx_full(slv_tx_full), .slv_busy(slv_busy)
`ifdef SPI_RESP_ERR_EN
    , .slv_err_clr(slv_err_clr), .slv_rx_overrun(slv_rx_overrun),
    .slv_tx_underrun(slv_tx_underrun)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mosi_buf [16];
  logic [7:0] miso_buf [16];
  logic       avail_at4;

  typedef struct {
    logic       wr;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    slv_din = d; slv_wr = 1'b1; clks(1); slv_wr = 1'b0;
  endtask

  task automatic rx_read();
    slv_rd = 1'b1; clks(1); slv_rd = 1'b0;
  endtask

  // Mode 0: MOSI set while SCK low, MISO sampled just before the rising edge.
  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      clks(4);
      mi[i] = spi_miso_out;
      spi_sck = 1'b1;
      clks(4);
      if (i == 0) avail_at4 = slv_data_avail;
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input int n);
    logic [7:0] m;
    spi_cs = 1'b0; clks(5);
    for (int b = 0; b < n; b++) begin
      spi_byte(mosi_buf[b], m);
      miso_buf[b] = m;
    end
    clks(4); spi_cs = 1'b1; clks(6);
  endtask

  initial begin
    logic [7:0] m;
    logic       miso_seen;
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h5A};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};

    clks(2);
    check("rst_miso", spi_miso_out, 0);
    check("rst_avail", slv_data_avail, 0);
    check("rst_dout", slv_dout, 0);
    check("rst_tx_empty", slv_tx_empty, 1);
    check("rst_tx_full", slv_tx_full, 0);
    check("rst_busy", slv_busy, 0);
    Rst = 1'b0;
    clks(6);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].wr) begin
        tx_write(vecs[v].tx);
        check("vec_tx_not_empty", slv_tx_empty, 0);
      end
      mosi_buf[0] = vecs[v].mosi;
      spi_frame(1);
      check("vec_miso", miso_buf[0], vecs[v].exp_miso);
      check("vec_avail_at4", avail_at4, 1);
      check("vec_dout", slv_dout, vecs[v].exp_rx);
      check("vec_tx_empty", slv_tx_empty, 1);
      rx_read();
      check("vec_avail_after_rd", slv_data_avail, 0);
    end

    // Underrun across two bytes of one frame
`ifdef SPI_RESP_ERR_EN
    slv_err_clr = 1'b1; clks(1); slv_err_clr = 1'b0;
    check("und_cleared_pre", slv_tx_underrun, 0);
`endif
    mosi_buf[0] = 8'h11; mosi_buf[1] = 8'h22;
    spi_frame(2);
    check("und_miso0", miso_buf[0], 8'hFF);
    check("und_miso1", miso_buf[1], 8'hFF);
    check("und_rx0", slv_dout, 8'h11);
    rx_read();
    check("und_rx1", slv_dout, 8'h22);
    rx_read();
    check("und_rx_empty", slv_data_avail, 0);
`ifdef SPI_RESP_ERR_EN
    check("und_flag", slv_tx_underrun, 1);
    slv_err_clr = 1'b1; clks(1); slv_err_clr = 1'b0;
    check("und_flag_clr", slv_tx_underrun, 0);
`endif

    // TX fill to full, ignored extra write, then RX overrun with 9 bytes
    for (int i = 0; i < 8; i++) tx_write(8'h10 + 8'(i));
    check("tx_full", slv_tx_full, 1);
    tx_write(8'hEE);
    check("tx_full_hold", slv_tx_full, 1);
    for (int i = 0; i < 9; i++) mosi_buf[i] = 8'(i);
    spi_frame(9);
    for (int i = 0; i < 8; i++) check("ovr_miso", miso_buf[i], 8'h10 + 8'(i));
    check("ovr_miso_fill", miso_buf[8], 8'hFF);
    for (int i = 0; i < 8; i++) begin
      check("ovr_rx", slv_dout, 8'(i));
      rx_read();
    end
    check("ovr_avail_end", slv_data_avail, 0);
`ifdef SPI_RESP_ERR_EN
    check("ovr_flag", slv_rx_overrun, 1);
`endif

    // Aborted frame after 5 bits, then full byte 0x81
    spi_cs = 1'b0; clks(5);
    check("abort_busy", slv_busy, 1);
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1; clks(4); spi_sck = 1'b1; clks(4); spi_sck = 1'b0;
    end
    clks(4); spi_cs = 1'b1; clks(6);
    check("abort_no_push", slv_data_avail, 0);
    check("abort_idle_busy", slv_busy, 0);
    mosi_buf[0] = 8'h81;
    spi_frame(1);
    check("abort_avail_at4", avail_at4, 1);
    check("abort_rx", slv_dout, 8'h81);
    rx_read();
    check("abort_rx_empty", slv_data_avail, 0);

    // Reset during bit 4 with CS held low
    spi_cs = 1'b0; clks(5);
    for (int i = 0; i < 4; i++) begin
      spi_mosi = 1'b0; clks(4); spi_sck = 1'b1; clks(4); spi_sck = 1'b0;
    end
    spi_mosi = 1'b1; clks(4); spi_sck = 1'b1; clks(2);
    Rst = 1'b1; clks(2); Rst = 1'b0;
    clks(2); spi_sck = 1'b0;
    miso_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = i[0]; clks(4);
      miso_seen = miso_seen | spi_miso_out;
      spi_sck = 1'b1; clks(4); spi_sck = 1'b0;
    end
    check("mrst_miso_idle", miso_seen, 0);
    check("mrst_no_push", slv_data_avail, 0);
    clks(4); spi_cs = 1'b1; clks(6);
    check("mrst_no_push_after", slv_data_avail, 0);
    mosi_buf[0] = 8'h5A;
    spi_frame(1);
    check("mrst_miso_fill", miso_buf[0], 8'hFF);
    check("mrst_rx", slv_dout, 8'h5A);
    check("mrst_avail", slv_data_avail, 1);
    m = slv_dout;
    rx_read();
    check("mrst_rx_empty", slv_data_avail, 0);
    check("mrst_dout_zero", slv_dout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
